// File: rtl/sram_bus_master_if.sv
// Command, bus and response signals of the SRAM bus-master stage.
// The master modport is the DUT view; slave is the requester/slave-model view.
interface sram_bus_master_if #(
  parameter int unsigned addr_width = 4,
  parameter int unsigned word_width = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [addr_width-1:0] cmd_addr;
  logic [word_width-1:0] cmd_wdata;
  logic                  hsel;
  logic [addr_width-1:0] haddr;
  logic                  hwrite;
  logic [word_width-1:0] hwdata;
  logic [word_width-1:0] hrdata;
  logic                  hready;
  logic                  rsp_valid;
  logic                  rsp_write;
  logic [word_width-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, hrdata, hready,
    output cmd_ready, hsel, haddr, hwrite, hwdata,
           rsp_valid, rsp_write, rsp_rdata, rsp_err, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, hrdata, hready,
    input  cmd_ready, hsel, haddr, hwrite, hwdata,
           rsp_valid, rsp_write, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/sram_bus_master.sv
// Buffered single-transfer bus master: command FIFO, ADDR/DATA bus sequencing,
// hready wait handling with a timeout watchdog, and one response per command.
module sram_bus_master #(
  parameter int unsigned addr_width  = 4,
  parameter int unsigned word_width  = 8,
  parameter int unsigned cmd_depth   = 4,
  parameter int unsigned timeout_cyc = 16
) (
  input  logic               hclk,
  input  logic               hrst,
  sram_bus_master_if.master  bus
);

  localparam int unsigned ptr_w = (cmd_depth > 1) ? $clog2(cmd_depth) : 1;
  localparam int unsigned cnt_w = $clog2(cmd_depth + 1);
  localparam int unsigned to_w  = (timeout_cyc > 1) ? $clog2(timeout_cyc + 1) : 1;
  // Only meaningful when the watchdog is enabled (timeout_cyc != 0).
  localparam logic [to_w-1:0] to_last = to_w'(timeout_cyc - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e                state_q, state_d;
  logic [to_w-1:0]       to_cnt_q, to_cnt_d;
  logic [addr_width-1:0] cur_addr_q, cur_addr_d;
  logic                  cur_write_q, cur_write_d;
  logic [word_width-1:0] cur_wdata_q, cur_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [word_width-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [addr_width-1:0] mem_addr  [cmd_depth];
  logic [word_width-1:0] mem_wdata [cmd_depth];
  logic                  mem_write [cmd_depth];
  logic [ptr_w-1:0]      wr_ptr_q, rd_ptr_q;
  logic [cnt_w-1:0]      count_q;
  logic                  full, empty, push, pop;

  assign full  = (count_q == cnt_w'(cmd_depth));
  assign empty = (count_q == '0);
  assign push  = bus.cmd_valid && !full;
  assign pop   = (state_q == IDLE) && !empty;

  // FIFO storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge hclk) begin
    if (push) begin
      mem_addr[wr_ptr_q]  <= bus.cmd_addr;
      mem_wdata[wr_ptr_q] <= bus.cmd_wdata;
      mem_write[wr_ptr_q] <= bus.cmd_write;
    end
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ptr_w'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ptr_w'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + cnt_w'(1);
        2'b01:   count_q <= count_q - cnt_w'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    cur_addr_d  = cur_addr_q;
    cur_write_d = cur_write_q;
    cur_wdata_d = cur_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d     = ADDR;
          cur_addr_d  = mem_addr[rd_ptr_q];
          cur_write_d = mem_write[rd_ptr_q];
          cur_wdata_d = mem_wdata[rd_ptr_q];
        end
      end
      ADDR: state_d = DATA;
      DATA: begin
        if (bus.hready) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = cur_write_q;
          rsp_rdata_d = cur_write_q ? '0 : bus.hrdata;
          rsp_err_d   = 1'b0;
        end else if ((timeout_cyc != 0) && (to_cnt_q == to_last)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = cur_write_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + to_w'(1);
        end
      end
      RESP: begin
        state_d  = IDLE;
        to_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      cur_addr_q  <= '0;
      cur_write_q <= 1'b0;
      cur_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      cur_addr_q  <= cur_addr_d;
      cur_write_q <= cur_write_d;
      cur_wdata_q <= cur_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Outputs are direct decodes of registered state only.
  assign bus.cmd_ready = !full;
  assign bus.hsel      = (state_q == ADDR) || (state_q == DATA);
  assign bus.haddr     = cur_addr_q;
  assign bus.hwrite    = cur_write_q;
  assign bus.hwdata    = cur_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_sram_bus_master.sv
// Directed bench for sram_bus_master: write, wait-state read, FIFO full,
// push/pop at count 1, timeout abort and asynchronous reset.
module tb_sram_bus_master;

  logic       hclk = 1'b0;
  logic       hrst;
  logic       echo;
  logic [7:0] hrdata_r;
  int         checks = 0;
  int         errors = 0;
  int         nrsp;
  logic       acc;
  logic       saw;

  sram_bus_master_if #(.addr_width(4), .word_width(8)) bif ();

  sram_bus_master #(
    .addr_width (4),
    .word_width (8),
    .cmd_depth  (4),
    .timeout_cyc(16)
  ) dut (
    .hclk(hclk),
    .hrst(hrst),
    .bus (bif)
  );

  always #5 hclk = ~hclk;

  // Slave read data: either a fixed value or an echo of the address being served.
  assign bif.hrdata = echo ? {4'hA, bif.haddr} : hrdata_r;

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic wr, input logic [3:0] a, input logic [7:0] d);
    bif.cmd_valid = 1'b1;
    bif.cmd_write = wr;
    bif.cmd_addr  = a;
    bif.cmd_wdata = d;
  endtask

  initial begin
    hrst          = 1'b1;
    echo          = 1'b0;
    hrdata_r      = 8'h00;
    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = 4'h0;
    bif.cmd_wdata = 8'h00;
    bif.hready    = 1'b1;

    // Reset values
    #2;
    check("rst_cmd_ready", 32'(bif.cmd_ready), 32'd1);
    check("rst_hsel",      32'(bif.hsel),      32'd0);
    check("rst_busy",      32'(bif.busy),      32'd0);
    check("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    check("rst_haddr",     32'(bif.haddr),     32'd0);
    repeat (2) tick;
    hrst = 1'b0;
    tick;

    // Single write, zero wait states
    offer(1'b1, 4'h3, 8'hA5);
    tick;
    bif.cmd_valid = 1'b0;
    check("w_idle_hsel", 32'(bif.hsel), 32'd0);
    check("w_idle_busy", 32'(bif.busy), 32'd1);
    tick;
    check("w_addr_hsel",   32'(bif.hsel),   32'd1);
    check("w_addr_haddr",  32'(bif.haddr),  32'h3);
    check("w_addr_hwrite", 32'(bif.hwrite), 32'd1);
    tick;
    check("w_data_hsel",   32'(bif.hsel),      32'd1);
    check("w_data_hwdata", 32'(bif.hwdata),    32'hA5);
    check("w_data_novld",  32'(bif.rsp_valid), 32'd0);
    tick;
    check("w_rsp_valid", 32'(bif.rsp_valid), 32'd1);
    check("w_rsp_write", 32'(bif.rsp_write), 32'd1);
    check("w_rsp_err",   32'(bif.rsp_err),   32'd0);
    check("w_rsp_rdata", 32'(bif.rsp_rdata), 32'd0);
    check("w_rsp_hsel",  32'(bif.hsel),      32'd0);
    tick;
    check("w_done_vld",  32'(bif.rsp_valid), 32'd0);
    check("w_done_busy", 32'(bif.busy),      32'd0);

    // Read with two wait states
    bif.hready = 1'b0;
    hrdata_r   = 8'hFF;
    offer(1'b0, 4'h7, 8'h00);
    tick;
    bif.cmd_valid = 1'b0;
    tick;
    check("r_addr_haddr",  32'(bif.haddr),  32'h7);
    check("r_addr_hwrite", 32'(bif.hwrite), 32'd0);
    repeat (3) tick;
    check("r_wait_hsel",  32'(bif.hsel),      32'd1);
    check("r_wait_novld", 32'(bif.rsp_valid), 32'd0);
    bif.hready = 1'b1;
    hrdata_r   = 8'h5C;
    tick;
    check("r_rsp_valid", 32'(bif.rsp_valid), 32'd1);
    check("r_rsp_rdata", 32'(bif.rsp_rdata), 32'h5C);
    check("r_rsp_write", 32'(bif.rsp_write), 32'd0);
    check("r_rsp_err",   32'(bif.rsp_err),   32'd0);
    tick;
    check("r_done_vld", 32'(bif.rsp_valid), 32'd0);

    // Push and pop on the same edge at count 1
    offer(1'b1, 4'h1, 8'h11);
    tick;
    offer(1'b1, 4'h2, 8'h22);
    tick;
    bif.cmd_valid = 1'b0;
    check("pp_a_hsel",  32'(bif.hsel),      32'd1);
    check("pp_a_haddr", 32'(bif.haddr),     32'h1);
    check("pp_ready",   32'(bif.cmd_ready), 32'd1);
    repeat (2) tick;
    check("pp_a_rsp", 32'(bif.rsp_valid), 32'd1);
    tick;
    check("pp_gap_hsel", 32'(bif.hsel), 32'd0);
    check("pp_gap_busy", 32'(bif.busy), 32'd1);
    tick;
    check("pp_b_hsel",  32'(bif.hsel),  32'd1);
    check("pp_b_haddr", 32'(bif.haddr), 32'h2);
    tick;
    check("pp_b_hwdata", 32'(bif.hwdata), 32'h22);
    tick;
    check("pp_b_rsp", 32'(bif.rsp_valid), 32'd1);
    tick;
    check("pp_idle_busy", 32'(bif.busy), 32'd0);

    // FIFO full: one in flight plus four queued, sixth command held
    bif.hready = 1'b0;
    echo       = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      offer(1'b0, 4'(i), 8'h00);
      check("full_ready_pre", 32'(bif.cmd_ready), 32'd1);
      tick;
    end
    offer(1'b0, 4'h6, 8'h00);
    check("full_ready_low", 32'(bif.cmd_ready), 32'd0);
    repeat (3) tick;
    check("full_ready_hold", 32'(bif.cmd_ready), 32'd0);
    check("full_busy",       32'(bif.busy),      32'd1);
    bif.hready = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 80 && nrsp < 6; c++) begin
      acc = bif.cmd_valid && bif.cmd_ready;
      tick;
      if (acc) bif.cmd_valid = 1'b0;
      if (bif.rsp_valid) begin
        nrsp++;
        check("full_order", 32'(bif.rsp_rdata), 32'({4'hA, 4'(nrsp)}));
      end
    end
    check("full_drain_count", 32'(nrsp), 32'd6);
    echo = 1'b0;
    tick;
    check("full_idle_busy", 32'(bif.busy), 32'd0);

    // Timeout abort on a stalled read, queued write then proceeds
    bif.hready = 1'b0;
    hrdata_r   = 8'hFF;
    offer(1'b0, 4'h9, 8'h00);
    tick;
    offer(1'b1, 4'hA, 8'h3C);
    tick;
    bif.cmd_valid = 1'b0;
    check("to_addr_haddr", 32'(bif.haddr), 32'h9);
    tick;
    repeat (15) tick;
    check("to_pre_novld", 32'(bif.rsp_valid), 32'd0);
    check("to_pre_hsel",  32'(bif.hsel),      32'd1);
    tick;
    check("to_rsp_valid", 32'(bif.rsp_valid), 32'd1);
    check("to_rsp_err",   32'(bif.rsp_err),   32'd1);
    check("to_rsp_rdata", 32'(bif.rsp_rdata), 32'd0);
    check("to_rsp_write", 32'(bif.rsp_write), 32'd0);
    bif.hready = 1'b1;
    tick;
    check("to_idle_vld",  32'(bif.rsp_valid), 32'd0);
    check("to_idle_busy", 32'(bif.busy),      32'd1);
    tick;
    check("to_next_haddr",  32'(bif.haddr),  32'hA);
    check("to_next_hwrite", 32'(bif.hwrite), 32'd1);
    tick;
    check("to_next_hwdata", 32'(bif.hwdata), 32'h3C);
    tick;
    check("to_next_rsp", 32'(bif.rsp_valid), 32'd1);
    check("to_next_err", 32'(bif.rsp_err),   32'd0);
    check("to_next_wr",  32'(bif.rsp_write), 32'd1);
    tick;

    // Asynchronous reset in the middle of a read data phase
    bif.hready = 1'b0;
    offer(1'b0, 4'h5, 8'h00);
    tick;
    offer(1'b1, 4'h6, 8'h66);
    tick;
    bif.cmd_valid = 1'b0;
    tick;
    check("ar_data_hsel", 32'(bif.hsel), 32'd1);
    #2;
    hrst = 1'b1;
    #1;
    check("ar_hsel",      32'(bif.hsel),      32'd0);
    check("ar_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    check("ar_busy",      32'(bif.busy),      32'd0);
    check("ar_cmd_ready", 32'(bif.cmd_ready), 32'd1);
    tick;
    hrst       = 1'b0;
    bif.hready = 1'b1;
    saw        = 1'b0;
    repeat (8) begin
      tick;
      saw = saw | bif.rsp_valid | bif.hsel | bif.busy;
    end
    check("ar_quiet_after", 32'(saw), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
